// File: rtl/asrs_fu_scheduler_pkg.sv
// Shared constants for the add/sub functional-unit scheduler.
package asrs_fu_scheduler_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TAG_W_DEF  = 3;
  localparam int CDB_W_DEF  = TAG_W_DEF + DATA_W_DEF;
  localparam int OP_W       = 3;

  localparam logic [OP_W-1:0]      OP_ADD   = 3'b000;
  localparam logic [OP_W-1:0]      OP_SUB   = 3'b001;
  localparam logic [TAG_W_DEF-1:0] TAG_NONE = 3'b000;

endpackage

// File: rtl/asrs_fu_scheduler_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] next_ptr
);

  // Scan N positions starting at ptr; the first hit wins and the pointer moves past it.
  always_comb begin
    int   idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    gnt      = '0;
    next_ptr = ptr;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = en;
        next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/asrs_fu_scheduler.sv
// Shares one add/sub unit between NUM_RS reservation stations and
// holds each result until the CDB grants a broadcast.
module asrs_fu_scheduler
  import asrs_fu_scheduler_pkg::*;
#(
  parameter int NUM_RS = 3,
  parameter int LAT    = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [NUM_RS-1:0]        rs_despacho,
  input  logic [NUM_RS*DATA_W-1:0] rs_valor1,
  input  logic [NUM_RS*DATA_W-1:0] rs_valor2,
  input  logic [NUM_RS*OP_W-1:0]   rs_op,
  input  logic [NUM_RS*TAG_W-1:0]  rs_id,
  output logic [NUM_RS-1:0]        rs_confirma,
  output logic                     cdb_req,
  input  logic                     cdb_gnt,
  output logic [TAG_W+DATA_W-1:0]  CDB,
  output logic                     busy,
  output logic                     err_tag0
);

  localparam int PW = $clog2(NUM_RS);

  // The mask is last cycle's grant; it is also what the stations see as confirma.
  logic [NUM_RS-1:0] mask;
  logic [PW-1:0]     ptr, next_ptr;
  logic [NUM_RS-1:0] gnt;
  logic              any, advance;

  logic [DATA_W-1:0] sel_a, sel_b;
  logic [OP_W-1:0]   sel_op;
  logic [TAG_W-1:0]  sel_tag;

  // Stage 0 is the entry stage; stage LAT-1 feeds the output register.
  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0][DATA_W-1:0] a_pipe, b_pipe;
  logic [LAT-1:0][OP_W-1:0]   op_pipe;
  logic [LAT-1:0][TAG_W-1:0]  tag_pipe;

  logic              out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] res;
  logic              last_tag0;

  assign advance = !out_valid || cdb_gnt;

  rr_arbiter #(.N(NUM_RS), .PW(PW)) u_arb (
    .req      (rs_despacho & ~mask),
    .ptr      (ptr),
    .en       (advance),
    .gnt      (gnt),
    .any      (any),
    .next_ptr (next_ptr)
  );

  // Route the winning station's operands to the pipe entry.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    sel_tag = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (gnt[i]) begin
        sel_a   = rs_valor1[i*DATA_W +: DATA_W];
        sel_b   = rs_valor2[i*DATA_W +: DATA_W];
        sel_op  = rs_op[i*OP_W +: OP_W];
        sel_tag = rs_id[i*TAG_W +: TAG_W];
      end
    end
  end

  // Final-stage ALU; carry and borrow fall off the top.
  assign res       = (op_pipe[LAT-1] == OP_SUB) ? a_pipe[LAT-1] - b_pipe[LAT-1]
                                                : a_pipe[LAT-1] + b_pipe[LAT-1];
  assign last_tag0 = (tag_pipe[LAT-1] == TAG_W'(TAG_NONE));

  // Pipe, output register, arbitration state and error flag; the whole pipe freezes on !advance.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      mask      <= '0;
      ptr       <= '0;
      vld_pipe  <= '0;
      a_pipe    <= '0;
      b_pipe    <= '0;
      op_pipe   <= '0;
      tag_pipe  <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
      err_tag0  <= 1'b0;
    end else begin
      mask <= gnt;
      if (advance) begin
        ptr         <= any ? next_ptr : ptr;
        vld_pipe[0] <= any;
        a_pipe[0]   <= sel_a;
        b_pipe[0]   <= sel_b;
        op_pipe[0]  <= sel_op;
        tag_pipe[0] <= sel_tag;
        for (int s = 1; s < LAT; s++) begin
          vld_pipe[s] <= vld_pipe[s-1];
          a_pipe[s]   <= a_pipe[s-1];
          b_pipe[s]   <= b_pipe[s-1];
          op_pipe[s]  <= op_pipe[s-1];
          tag_pipe[s] <= tag_pipe[s-1];
        end
        // Tag-0 results are dropped here instead of being broadcast.
        out_valid <= vld_pipe[LAT-1] && !last_tag0;
        out_tag   <= tag_pipe[LAT-1];
        out_data  <= res;
        if (vld_pipe[LAT-1] && last_tag0) err_tag0 <= 1'b1;
      end
    end
  end

  assign rs_confirma = mask;
  assign cdb_req     = out_valid;
  assign CDB         = (out_valid && cdb_gnt) ? {out_tag, out_data} : '0;
  assign busy        = (|vld_pipe) || out_valid;

endmodule

// File: tb/tb_asrs_fu_scheduler.sv
// Random + directed bench against a transaction-level model of the scheduler.
module tb_asrs_fu_scheduler;

  localparam int N   = 3;
  localparam int LAT = 2;
  localparam int DW  = 16;
  localparam int TW  = 3;

  logic              CLK = 1'b0;
  logic              CLR;
  logic [N-1:0]      rs_despacho;
  logic [N*DW-1:0]   rs_valor1, rs_valor2;
  logic [N*3-1:0]    rs_op;
  logic [N*TW-1:0]   rs_id;
  logic [N-1:0]      rs_confirma;
  logic              cdb_req, cdb_gnt;
  logic [TW+DW-1:0]  CDB;
  logic              busy, err_tag0;

  asrs_fu_scheduler #(.NUM_RS(N), .LAT(LAT), .DATA_W(DW), .TAG_W(TW)) dut (
    .CLK(CLK), .CLR(CLR), .rs_despacho(rs_despacho), .rs_valor1(rs_valor1),
    .rs_valor2(rs_valor2), .rs_op(rs_op), .rs_id(rs_id), .rs_confirma(rs_confirma),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .CDB(CDB), .busy(busy), .err_tag0(err_tag0)
  );

  always #5 CLK = ~CLK;

  // Model: in-flight ops carry their final result from the moment of grant.
  typedef struct { bit v; logic [TW-1:0] tag; logic [DW-1:0] res; } slot_t;
  slot_t       slots[LAT];
  int          m_ptr, m_conf;
  bit          m_ov, m_err;
  logic [TW-1:0] m_otag;
  logic [DW-1:0] m_odata;

  // Stations: each holds one op and requests until confirmed.
  logic [DW-1:0] st_a[N], st_b[N];
  logic [2:0]    st_op[N];
  logic [TW-1:0] st_id[N];
  bit            st_req[N], st_drop[N];

  int            n_cmp = 0, n_err = 0, cyc = 0, conf_cyc = -1, seen_cyc = -1;
  logic [18:0]   seen_cdb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [2:0] op);
    return (op == 3'b001) ? a - b : a + b;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_conf = -1; m_ov = 0; m_err = 0; m_otag = '0; m_odata = '0;
    for (int s = 0; s < LAT; s++) slots[s] = '{0, '0, '0};
  endtask

  // One clock: drive, check combinational CDB, step model at the edge, check registered outputs.
  task automatic cycle();
    int win, idx, onehot;
    bit adv, any_v;
    logic [18:0] exp_cdb;
    for (int i = 0; i < N; i++) begin
      rs_despacho[i]       = st_req[i];
      rs_valor1[i*DW +: DW] = st_a[i];
      rs_valor2[i*DW +: DW] = st_b[i];
      rs_op[i*3 +: 3]       = st_op[i];
      rs_id[i*TW +: TW]     = st_id[i];
    end
    #1;
    adv     = !m_ov || cdb_gnt;
    exp_cdb = (m_ov && cdb_gnt) ? {m_otag, m_odata} : 19'h0;
    chk("cdb", 32'(CDB), 32'(exp_cdb));
    if (CDB != 0) begin seen_cdb = CDB; seen_cyc = cyc; end
    win = -1;
    if (adv)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && st_req[idx] && m_conf != idx) win = idx;
      end
    @(posedge CLK);
    cyc++;
    if (CLR) model_reset();
    else begin
      if (adv) begin
        if (slots[LAT-1].v && slots[LAT-1].tag == 0) begin m_err = 1; m_ov = 0; end
        else if (slots[LAT-1].v) begin m_ov = 1; m_otag = slots[LAT-1].tag; m_odata = slots[LAT-1].res; end
        else m_ov = 0;
        for (int s = LAT - 1; s > 0; s--) slots[s] = slots[s-1];
        slots[0] = '{0, '0, '0};
        if (win >= 0) begin
          slots[0] = '{1, st_id[win], alu(st_a[win], st_b[win], st_op[win])};
          m_ptr = (win + 1) % N;
        end
      end
      m_conf = win;
    end
    #1;
    onehot = (m_conf >= 0) ? (1 << m_conf) : 0;
    any_v = m_ov;
    for (int s = 0; s < LAT; s++) any_v |= slots[s].v;
    chk("confirma", 32'(rs_confirma), onehot);
    chk("cdb_req", 32'(cdb_req), 32'(m_ov));
    chk("busy", 32'(busy), 32'(any_v));
    chk("err_tag0", 32'(err_tag0), 32'(m_err));
    if (rs_confirma != 0) conf_cyc = cyc;
  endtask

  // Station behaviour: drop request on the edge after seeing confirma; idle ones may issue.
  task automatic stations(input int p_issue, input int p_tag0);
    for (int i = 0; i < N; i++) begin
      if (!st_req[i] && int'($urandom_range(99)) < p_issue) begin
        st_req[i] = 1;
        st_a[i]   = DW'($urandom);
        st_b[i]   = DW'($urandom);
        st_op[i]  = 3'($urandom_range(3));
        st_id[i]  = (int'($urandom_range(99)) < p_tag0) ? '0 : TW'(i + 1);
      end
      if (st_drop[i]) begin st_req[i] = 0; st_drop[i] = 0; end
      if (m_conf == i) st_drop[i] = 1;
    end
  endtask

  task automatic put(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [2:0] op, input logic [TW-1:0] id);
    st_a[i] = a; st_b[i] = b; st_op[i] = op; st_id[i] = id; st_req[i] = 1;
  endtask

  initial begin
    int gp[3];
    gp = '{90, 40, 15};
    for (int i = 0; i < N; i++) begin
      st_req[i] = 0; st_drop[i] = 0; st_a[i] = '0; st_b[i] = '0; st_op[i] = '0; st_id[i] = '0;
    end
    model_reset();
    CLR = 1; cdb_gnt = 0;
    repeat (3) cycle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(cdb_req), 0);
    chk("rst_conf", 32'(rs_confirma), 0);
    chk("rst_err", 32'(err_tag0), 0);
    CLR = 0; cdb_gnt = 1;

    // Single add: tag 1, 5+3
    seen_cdb = '0; conf_cyc = -1;
    put(0, 16'd5, 16'd3, 3'b000, 3'd1);
    repeat (8) begin cycle(); stations(0, 0); end
    chk("t1_cdb", 32'(seen_cdb), 32'h1_0008);
    chk("t1_lat", seen_cyc - conf_cyc, LAT);

    // Subtract wrap: 0-1, tag 2
    seen_cdb = '0;
    put(1, 16'd0, 16'd1, 3'b001, 3'd2);
    repeat (8) begin cycle(); stations(0, 0); end
    chk("t2_cdb", 32'(seen_cdb), 32'h2_FFFF);

    // Tag 0: confirmed but never broadcast
    seen_cdb = '0;
    put(2, 16'd7, 16'd9, 3'b000, 3'd0);
    repeat (8) begin cycle(); stations(0, 0); end
    chk("t0_cdb", 32'(seen_cdb), 0);
    chk("t0_err", 32'(err_tag0), 1);

    // Reset the cycle after a grant
    put(0, 16'd11, 16'd22, 3'b000, 3'd1);
    conf_cyc = -1;
    for (int t = 0; t < 5 && conf_cyc < 0; t++) begin cycle(); stations(0, 0); end
    chk("t6_granted", 32'(conf_cyc >= 0), 1);
    CLR = 1; cycle(); stations(0, 0); CLR = 0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_req", 32'(cdb_req), 0);
    seen_cdb = '0;
    repeat (6) begin cycle(); stations(0, 0); end
    chk("t6_stale", 32'(seen_cdb), 0);

    // Random traffic under varying bus back-pressure
    for (int p = 0; p < 3; p++)
      repeat (400) begin
        stations(60, 5);
        cdb_gnt = int'($urandom_range(99)) < gp[p];
        CLR     = ($urandom_range(199) == 0);
        cycle();
      end
    CLR = 0; cdb_gnt = 1;
    repeat (10) begin stations(0, 0); cycle(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
